// File: rtl/key_latch_pkg.sv
// Shared definitions for the key-protected latch bank.
// Holds the FSM state encoding and the default output obfuscation mask.
package key_latch_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED,
        ST_SHIFT,
        ST_CHECK,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_t;

    localparam int MAX_CHANNELS = 64;

    // Odd bit positions set; callers truncate to their channel count.
    function automatic logic [MAX_CHANNELS-1:0] default_obf_mask();
        return {(MAX_CHANNELS/2){2'b10}};
    endfunction

endpackage

// File: rtl/key_shift_cmp.sv
// Serial key capture: MSB-first shift register, bit counter and comparison
// against the stored key.
module key_shift_cmp #(
    parameter int                   KEY_WIDTH = 16,
    parameter logic [KEY_WIDTH-1:0] KEY_VALUE = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift_en,
    input  logic key_bit,
    output logic last,
    output logic match
);

    localparam int            CW       = $clog2(KEY_WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(KEY_WIDTH - 1);

    logic [KEY_WIDTH-1:0] sr;
    logic [CW-1:0]        cnt;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            sr  <= {sr[KEY_WIDTH-2:0], key_bit};
            cnt <= cnt + CW'(1);
        end
    end

    // High while the next accepted bit completes the key.
    assign last  = (cnt == LAST_IDX);
    assign match = (sr == KEY_VALUE);

endmodule

// File: rtl/key_latch_bank.sv
// Data latch bank whose outputs stay XOR-obfuscated until a serial key unlocks it.
// Define KEY_LATCH_LOCKOUT_EN to add a permanent LOCKOUT state after MAX_FAIL bad keys.
module key_latch_bank
    import key_latch_pkg::*;
#(
    parameter int                   WIDTH     = 4,
    parameter int                   KEY_WIDTH = 16,
    parameter logic [KEY_WIDTH-1:0] KEY_VALUE = KEY_WIDTH'(16'hC3A5),
    parameter logic [WIDTH-1:0]     OBF_MASK  = WIDTH'(default_obf_mask()),
    parameter int                   MAX_FAIL  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             le,
    input  logic             key_start,
    input  logic             key_valid,
    input  logic             key_bit,
    input  logic             relock,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             unlocked,
    output logic             locked_out
);

    localparam int            FW       = $clog2(MAX_FAIL + 1);
    localparam logic [FW-1:0] FAIL_SAT = FW'(MAX_FAIL);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data;
    logic [FW-1:0]    fail_cnt;
    logic             sc_clr, sc_shift, sc_last, sc_match;
    logic             fail_inc, fail_clr;

    key_shift_cmp #(
        .KEY_WIDTH (KEY_WIDTH),
        .KEY_VALUE (KEY_VALUE)
    ) u_shift_cmp (
        .clk      (clk),
        .rst      (rst),
        .clr      (sc_clr),
        .shift_en (sc_shift),
        .key_bit  (key_bit),
        .last     (sc_last),
        .match    (sc_match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_LOCKED;
            data     <= '0;
            fail_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (le)
                data <= d;
            if (fail_clr)
                fail_cnt <= '0;
            else if (fail_inc && fail_cnt != FAIL_SAT)
                fail_cnt <= fail_cnt + FW'(1);
        end
    end

`ifdef KEY_LATCH_LOCKOUT_EN
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
    logic fail_at_limit;
    // The failure being scored in CHECK is the one that reaches MAX_FAIL.
    assign fail_at_limit = (fail_cnt >= FAIL_LAST);
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        sc_clr    = 1'b0;
        sc_shift  = 1'b0;
        fail_inc  = 1'b0;
        fail_clr  = 1'b0;
        case (state)
            ST_LOCKED: begin
                if (key_start) begin
                    state_nxt = ST_SHIFT;
                    sc_clr    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (key_start) begin
                    sc_clr = 1'b1;
                end else if (key_valid) begin
                    sc_shift = 1'b1;
                    if (sc_last)
                        state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Wipe the captured key whichever way the check goes.
                sc_clr = 1'b1;
                if (sc_match) begin
                    state_nxt = ST_UNLOCKED;
                    fail_clr  = 1'b1;
                end else begin
                    fail_inc  = 1'b1;
`ifdef KEY_LATCH_LOCKOUT_EN
                    state_nxt = fail_at_limit ? ST_LOCKOUT : ST_LOCKED;
`else
                    state_nxt = ST_LOCKED;
`endif
                end
            end
            ST_UNLOCKED: begin
                if (relock)
                    state_nxt = ST_LOCKED;
            end
`ifdef KEY_LATCH_LOCKOUT_EN
            ST_LOCKOUT: begin
                state_nxt = ST_LOCKOUT;
            end
`endif
            default: begin
                state_nxt = ST_LOCKED;
            end
        endcase
    end

    assign unlocked = (state == ST_UNLOCKED);
    assign q        = unlocked ? data : (data ^ OBF_MASK);
    assign q_n      = ~q;

`ifdef KEY_LATCH_LOCKOUT_EN
    assign locked_out = (state == ST_LOCKOUT);
`else
    assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_key_latch_bank.sv
// Scoreboard bench for key_latch_bank (WIDTH=4, KEY_WIDTH=8, KEY_VALUE=8'hA5, MAX_FAIL=3).
// Expectations are queued as stimulus is driven and compared on the following falling edge.
`timescale 1ns/1ps
module tb_key_latch_bank;

    localparam logic [3:0] MASK = 4'hA;
`ifdef KEY_LATCH_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d = '0;
    logic       le = 1'b0, key_start = 1'b0, key_valid = 1'b0, key_bit = 1'b0, relock = 1'b0;
    logic [3:0] q, q_n;
    logic       unlocked, locked_out;

    typedef struct {
        string      name;
        int         cyc;
        logic [3:0] q;
        logic       unl;
        logic       lo;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [3:0] m_data = '0;
    logic       m_unl = 1'b0;
    logic       m_lo = 1'b0;

    key_latch_bank #(
        .WIDTH     (4),
        .KEY_WIDTH (8),
        .KEY_VALUE (8'hA5),
        .MAX_FAIL  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .le         (le),
        .key_start  (key_start),
        .key_valid  (key_valid),
        .key_bit    (key_bit),
        .relock     (relock),
        .q          (q),
        .q_n        (q_n),
        .unlocked   (unlocked),
        .locked_out (locked_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard drain: outputs are registered, so the falling edge is a stable sample point.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            total++;
            if (cur.cyc != cyc) begin
                bad++;
                $display("FAIL %s: expectation for cycle %0d sampled at cycle %0d", cur.name, cur.cyc, cyc);
            end else if (q !== cur.q || q_n !== ~cur.q || unlocked !== cur.unl || locked_out !== cur.lo) begin
                bad++;
                $display("FAIL %s: got q=%h q_n=%h unlocked=%b locked_out=%b, want q=%h q_n=%h unlocked=%b locked_out=%b",
                         cur.name, q, q_n, unlocked, locked_out, cur.q, ~cur.q, cur.unl, cur.lo);
            end
        end
    end

    function automatic void expect_out(input string name);
        exp_t e;
        e.name = name;
        e.cyc  = cyc + 1;
        e.q    = m_unl ? m_data : (m_data ^ MASK);
        e.unl  = m_unl;
        e.lo   = m_lo;
        sb.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic tick(input string name);
        expect_out(name);
        step();
    endtask

    task automatic go_idle();
        le = 1'b0; key_start = 1'b0; key_valid = 1'b0; key_bit = 1'b0; relock = 1'b0;
    endtask

    // key_start with a valid bit in the same cycle; that bit must be dropped.
    task automatic key_start_pulse(input string name);
        key_start = 1'b1; key_valid = 1'b1; key_bit = 1'b1;
        tick(name);
        key_start = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, input bit gaps, input string name);
        for (int i = 7; i > 7 - n; i--) begin
            if (gaps && (i % 3 == 0)) begin
                key_valid = 1'b0; key_bit = ~v[i];
                tick({name, "_gap"});
            end
            key_valid = 1'b1; key_bit = v[i];
            tick(name);
        end
        key_valid = 1'b0; key_bit = 1'b0;
    endtask

    task automatic attempt(input logic [7:0] v, input string name);
        key_start_pulse({name, "_start"});
        send_bits(v, 8, 1'b0, name);
    endtask

    task automatic load(input logic [3:0] v, input string name);
        d = v; le = 1'b1; m_data = v;
        tick(name);
        le = 1'b0;
    endtask

    task automatic do_reset(input string name);
        go_idle();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (q !== MASK) begin
            bad++; $display("FAIL %s_q: got %h want %h", name, q, MASK);
        end
        total++;
        if (q_n !== ~MASK) begin
            bad++; $display("FAIL %s_q_n: got %h want %h", name, q_n, ~MASK);
        end
        total++;
        if (unlocked !== 1'b0) begin
            bad++; $display("FAIL %s_unlocked: got %b want 0", name, unlocked);
        end
        total++;
        if (locked_out !== 1'b0) begin
            bad++; $display("FAIL %s_locked_out: got %b want 0", name, locked_out);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        m_data = '0; m_unl = 1'b0; m_lo = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        total++;
        if (q !== MASK || q_n !== ~MASK || unlocked !== 1'b0 || locked_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: got q=%h q_n=%h unlocked=%b locked_out=%b, want q=%h q_n=%h unlocked=0 locked_out=0",
                     q, q_n, unlocked, locked_out, MASK, ~MASK);
        end
        rst = 1'b0;
        load(4'hF, "load_pre_reset");
        do_reset("reset_async");
    endtask

    task automatic test_load();
        load(4'h3, "load_3");
        d = 4'hC;
        tick("hold_without_le");
    endtask

    task automatic test_unlock();
        attempt(8'hA5, "good_key");
        m_unl = 1'b1;
        tick("unlock_after_check");
        load(4'h5, "load_unlocked");
        key_start = 1'b1; key_valid = 1'b1; key_bit = 1'b0;
        tick("key_ignored_unlocked");
        go_idle();
        relock = 1'b1; m_unl = 1'b0;
        tick("relock");
        relock = 1'b0;
        tick("stay_locked");
    endtask

    task automatic test_restart();
        key_start_pulse("restart_first_start");
        send_bits(8'b1011_0000, 5, 1'b0, "partial_key");
        key_start_pulse("restart_second_start");
        send_bits(8'hA5, 8, 1'b1, "gapped_key");
        m_unl = 1'b1;
        tick("restart_unlock");
        relock = 1'b1; m_unl = 1'b0;
        tick("restart_relock");
        relock = 1'b0;
    endtask

    task automatic test_bad_key();
        for (int k = 0; k < 3; k++) begin
            attempt(8'hA4, "bad_key");
            if (LOCKOUT && k == 2)
                m_lo = 1'b1;
            tick("bad_key_exit");
        end
        attempt(8'hA5, "key_after_fails");
        m_unl = !m_lo;
        tick("key_after_fails_exit");
        relock = 1'b1; m_unl = 1'b0;
        tick("relock_after_fails");
        relock = 1'b0;
        load(4'h6, "load_after_fails");
        if (m_lo)
            do_reset("reset_lockout");
    endtask

    task automatic test_reset_mid_shift();
        for (int k = 0; k < 2; k++) begin
            attempt(8'hA4, "pre_reset_bad");
            tick("pre_reset_bad_exit");
        end
        key_start_pulse("mid_start");
        send_bits(8'hA5, 3, 1'b0, "mid_bits");
        do_reset("reset_mid_shift");
        // Fail count restarted at 0, so two more misses stay short of lockout.
        for (int k = 0; k < 2; k++) begin
            attempt(8'hA4, "post_reset_bad");
            tick("post_reset_bad_exit");
        end
        attempt(8'hA5, "post_reset_good");
        m_unl = 1'b1;
        tick("post_reset_unlock");
        relock = 1'b1; m_unl = 1'b0;
        tick("post_reset_relock");
        relock = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_unlock();
        test_restart();
        test_bad_key();
        test_reset_mid_shift();
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
